rsa_job_arbiter: RTL and testbench

Front-end controller that shares one `rsa_unit` core between two independent requesters. It arbitrates round-robin between them and latches the winning operand set. It sequences the core's active-low `clear`, waits for `eoc` under a watchdog timeout, and returns the result to the owning requester over a valid/ready handshake. It sits between the host-side register blocks and the single `rsa_unit` instance.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/rsa_job_arbiter.sv | 148 ++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the rsa_unit job arbiter: FSM state encoding and requester index.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } rsa_arb_state_t;

  typedef logic req_id_t;

  // Collapse a one-hot two-bit grant into the requester index.
  function automatic req_id_t grant_to_id(input logic [1:0] grant);
    return grant[1] ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2
  import rsa_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] grant
);

  // Combinational grant selection, one-hot or zero.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one rsa_unit core between two requesters: round-robin grant, clear
// sequencing, watchdog-bounded run and a per-requester response handshake.
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_p,
  input  logic [WIDTH-1:0] req0_e,
  input  logic [WIDTH-1:0] req0_m,
  input  logic [WIDTH-1:0] req0_const,
  input  logic [WIDTH-1:0] req1_p,
  input  logic [WIDTH-1:0] req1_e,
  input  logic [WIDTH-1:0] req1_m,
  input  logic [WIDTH-1:0] req1_const,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic             busy,
  output logic             core_clear,
  output logic [WIDTH-1:0] core_p,
  output logic [WIDTH-1:0] core_e,
  output logic [WIDTH-1:0] core_m,
  output logic [WIDTH-1:0] core_const,
  input  logic             core_eoc,
  input  logic [WIDTH-1:0] core_c
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  rsa_arb_state_t state;
  rsa_arb_state_t next_state;
  req_id_t        last;
  req_id_t        owner;
  logic [CW-1:0]  cnt;
  logic [1:0]     grant;
  logic           timed_out;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (grant)
  );

  assign timed_out = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= next_state;
    end else begin
      state <= state;
    end
  end

  // Next-state logic; eoc takes priority over the watchdog in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant != 2'b00) next_state = LOAD;
        else                next_state = IDLE;
      end
      LOAD: next_state = RUN;
      RUN: begin
        if (core_eoc || timed_out) next_state = RESP;
        else                       next_state = RUN;
      end
      RESP: begin
        if (rsp_ready[owner]) next_state = IDLE;
        else                  next_state = RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the state register; req_ready is the live grant in IDLE.
  always_comb begin
    busy       = (state != IDLE);
    core_clear = (state == RUN);
    if (state == IDLE && ena && !rst) begin
      req_ready = grant;
    end else begin
      req_ready = 2'b00;
    end
    if (state == RESP) begin
      rsp_valid = (owner == 1'b1) ? 2'b10 : 2'b01;
    end else begin
      rsp_valid = 2'b00;
    end
  end

  // Operand capture, round-robin pointer, watchdog counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= {CW{1'b0}};
      core_p     <= {WIDTH{1'b0}};
      core_e     <= {WIDTH{1'b0}};
      core_m     <= {WIDTH{1'b0}};
      core_const <= {WIDTH{1'b0}};
      rsp_c      <= {WIDTH{1'b0}};
      rsp_err    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            last       <= grant_to_id(grant);
            owner      <= grant_to_id(grant);
            core_p     <= grant[1] ? req1_p     : req0_p;
            core_e     <= grant[1] ? req1_e     : req0_e;
            core_m     <= grant[1] ? req1_m     : req0_m;
            core_const <= grant[1] ? req1_const : req0_const;
          end else begin
            owner <= owner;
          end
        end
        LOAD: cnt <= {CW{1'b0}};
        RUN: begin
          if (core_eoc) begin
            rsp_c   <= core_c;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_c   <= {WIDTH{1'b0}};
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: cnt <= cnt;
      endcase
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter: instance a uses the default watchdog,
// instance b a 16-cycle watchdog; each drives a counting core model.
module tb_rsa_job_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic [7:0] p0 = 8'h00, e0 = 8'h00, m0 = 8'h00, k0 = 8'h00;
  logic [7:0] p1 = 8'h00, e1 = 8'h00, m1 = 8'h00, k1 = 8'h00;
  logic [1:0]  req_valid_v [2];
  logic [1:0]  rsp_ready_v [2];
  logic [15:0] n_v [2];
  logic [7:0]  res_v [2];

  wire [1:0] req_ready_w [2];
  wire [1:0] rsp_valid_w [2];
  wire [7:0] rsp_c_w [2];
  wire       rsp_err_w [2];
  wire       busy_w [2];
  wire       core_clear_w [2];
  wire [7:0] core_p_w [2];
  wire [7:0] core_e_w [2];
  wire [7:0] core_m_w [2];
  wire [7:0] core_k_w [2];
  logic [15:0] mcnt0 = 16'd0, mcnt1 = 16'd0;
  logic eoc0, eoc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Core models: count enabled cycles while clear is high, then hold eoc.
  always @(posedge clk) begin
    if (!core_clear_w[0]) mcnt0 <= 16'd0;
    else if (ena && mcnt0 < n_v[0]) mcnt0 <= mcnt0 + 16'd1;
  end
  always @(posedge clk) begin
    if (!core_clear_w[1]) mcnt1 <= 16'd0;
    else if (ena && mcnt1 < n_v[1]) mcnt1 <= mcnt1 + 16'd1;
  end
  assign eoc0 = core_clear_w[0] && (mcnt0 >= n_v[0]);
  assign eoc1 = core_clear_w[1] && (mcnt1 >= n_v[1]);

  rsa_job_arbiter #(.WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_w[0]),
    .req0_p(p0), .req0_e(e0), .req0_m(m0), .req0_const(k0),
    .req1_p(p1), .req1_e(e1), .req1_m(m1), .req1_const(k1),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready_v[0]),
    .rsp_c(rsp_c_w[0]), .rsp_err(rsp_err_w[0]), .busy(busy_w[0]),
    .core_clear(core_clear_w[0]), .core_p(core_p_w[0]), .core_e(core_e_w[0]),
    .core_m(core_m_w[0]), .core_const(core_k_w[0]),
    .core_eoc(eoc0), .core_c(res_v[0])
  );

  rsa_job_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_w[1]),
    .req0_p(p0), .req0_e(e0), .req0_m(m0), .req0_const(k0),
    .req1_p(p1), .req1_e(e1), .req1_m(m1), .req1_const(k1),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready_v[1]),
    .rsp_c(rsp_c_w[1]), .rsp_err(rsp_err_w[1]), .busy(busy_w[1]),
    .core_clear(core_clear_w[1]), .core_p(core_p_w[1]), .core_e(core_e_w[1]),
    .core_m(core_m_w[1]), .core_const(core_k_w[1]),
    .core_eoc(eoc1), .core_c(res_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete job on instance sel: grant, LOAD, RUN of `run` cycles, RESP, ack.
  task automatic do_job(input int sel, input logic [1:0] g,
                        input logic [7:0] ep, input logic [7:0] ee,
                        input logic [7:0] em, input logic [7:0] ek,
                        input logic [15:0] n, input int run, input logic [7:0] res,
                        input logic [7:0] ec, input logic eerr);
    n_v[sel] = n;
    res_v[sel] = res;
    #1;
    check("grant", 32'(req_ready_w[sel]), 32'(g));
    tick();
    req_valid_v[sel] = req_valid_v[sel] & ~g;
    check("load_busy", 32'(busy_w[sel]), 32'd1);
    check("load_clear", 32'(core_clear_w[sel]), 32'd0);
    check("load_ready", 32'(req_ready_w[sel]), 32'd0);
    check("core_p", 32'(core_p_w[sel]), 32'(ep));
    check("core_e", 32'(core_e_w[sel]), 32'(ee));
    check("core_m", 32'(core_m_w[sel]), 32'(em));
    check("core_const", 32'(core_k_w[sel]), 32'(ek));
    tick();
    check("run_clear", 32'(core_clear_w[sel]), 32'd1);
    repeat (run) tick();
    check("pre_rsp", 32'(rsp_valid_w[sel]), 32'd0);
    tick();
    check("rsp_valid", 32'(rsp_valid_w[sel]), 32'(g));
    check("rsp_c", 32'(rsp_c_w[sel]), 32'(ec));
    check("rsp_err", 32'(rsp_err_w[sel]), 32'(eerr));
    check("resp_clear", 32'(core_clear_w[sel]), 32'd0);
    rsp_ready_v[sel] = g;
    tick();
    rsp_ready_v[sel] = 2'b00;
    check("idle_busy", 32'(busy_w[sel]), 32'd0);
  endtask

  initial begin
    req_valid_v[0] = 2'b00; req_valid_v[1] = 2'b00;
    rsp_ready_v[0] = 2'b00; rsp_ready_v[1] = 2'b00;
    n_v[0] = 16'd0; n_v[1] = 16'd0;
    res_v[0] = 8'h00; res_v[1] = 8'h00;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready_w[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("rst_rsp_c", 32'(rsp_c_w[0]), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_clear", 32'(core_clear_w[0]), 32'd0);
    check("rst_core_p", 32'(core_p_w[0]), 32'd0);
    rst = 1'b0;

    // Single job: response exactly 23 cycles after the grant.
    p0 = 8'h05; e0 = 8'h03; m0 = 8'h0D; k0 = 8'h09;
    req_valid_v[0] = 2'b01;
    do_job(0, 2'b01, 8'h05, 8'h03, 8'h0D, 8'h09, 16'd20, 20, 8'h5A, 8'h5A, 1'b0);

    // Tie arbitration from reset: 0, 1, 0.
    rst = 1'b1; tick(); rst = 1'b0;
    p0 = 8'h11; e0 = 8'h12; m0 = 8'h13; k0 = 8'h14;
    p1 = 8'h21; e1 = 8'h22; m1 = 8'h23; k1 = 8'h24;
    req_valid_v[0] = 2'b11;
    do_job(0, 2'b01, 8'h11, 8'h12, 8'h13, 8'h14, 16'd3, 3, 8'h31, 8'h31, 1'b0);
    req_valid_v[0] = 2'b11;
    do_job(0, 2'b10, 8'h21, 8'h22, 8'h23, 8'h24, 16'd4, 4, 8'h42, 8'h42, 1'b0);
    req_valid_v[0] = 2'b11;
    do_job(0, 2'b01, 8'h11, 8'h12, 8'h13, 8'h14, 16'd2, 2, 8'h53, 8'h53, 1'b0);
    req_valid_v[0] = 2'b00;

    // Enable low in IDLE blocks the grant.
    ena = 1'b0;
    p0 = 8'h45; e0 = 8'h46; m0 = 8'h47; k0 = 8'h48;
    req_valid_v[0] = 2'b01;
    #1;
    check("ena_ready", 32'(req_ready_w[0]), 32'd0);
    tick();
    check("ena_idle", 32'(busy_w[0]), 32'd0);
    ena = 1'b1;

    // Enable low for 5 RUN cycles, then response backpressure.
    n_v[0] = 16'd20; res_v[0] = 8'h3C;
    #1;
    check("bp_grant", 32'(req_ready_w[0]), 32'd1);
    tick();
    req_valid_v[0] = 2'b00;
    tick();
    check("bp_run", 32'(core_clear_w[0]), 32'd1);
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) begin
      check("bp_frozen", 32'({busy_w[0], core_clear_w[0], rsp_valid_w[0]}), 32'b1100);
      tick();
    end
    ena = 1'b1;
    repeat (17) tick();
    check("bp_pre_rsp", 32'(rsp_valid_w[0]), 32'd0);
    tick();
    check("bp_rsp_valid", 32'(rsp_valid_w[0]), 32'd1);
    check("bp_rsp_c", 32'(rsp_c_w[0]), 32'h3C);
    rsp_ready_v[0] = 2'b10;
    repeat (10) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid_w[0]), 32'd1);
      check("bp_hold_c", 32'(rsp_c_w[0]), 32'h3C);
    end
    rsp_ready_v[0] = 2'b01;
    tick();
    rsp_ready_v[0] = 2'b00;
    check("bp_idle", 32'(busy_w[0]), 32'd0);

    // Reset in the middle of RUN drops the job.
    p0 = 8'h66; e0 = 8'h67; m0 = 8'h68; k0 = 8'h69;
    n_v[0] = 16'd20; res_v[0] = 8'hDD;
    req_valid_v[0] = 2'b01;
    #1;
    check("mr_grant", 32'(req_ready_w[0]), 32'd1);
    tick();
    req_valid_v[0] = 2'b00;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_busy", 32'(busy_w[0]), 32'd0);
    check("mr_clear", 32'(core_clear_w[0]), 32'd0);
    check("mr_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("mr_rsp_c", 32'(rsp_c_w[0]), 32'd0);
    check("mr_rsp_err", 32'(rsp_err_w[0]), 32'd0);
    check("mr_core_p", 32'(core_p_w[0]), 32'd0);
    check("mr_core_const", 32'(core_k_w[0]), 32'd0);
    check("mr_req_ready", 32'(req_ready_w[0]), 32'd0);
    repeat (25) begin
      tick();
      check("mr_no_rsp", 32'(rsp_valid_w[0]), 32'd0);
    end

    // Watchdog on instance b: 16 RUN cycles, then an error response.
    p0 = 8'h77; e0 = 8'h78; m0 = 8'h79; k0 = 8'h7A;
    req_valid_v[1] = 2'b01;
    do_job(1, 2'b01, 8'h77, 8'h78, 8'h79, 8'h7A, 16'hFFFF, 15, 8'h99, 8'h00, 1'b1);

    // Next job on instance b succeeds normally.
    p1 = 8'h81; e1 = 8'h82; m1 = 8'h83; k1 = 8'h84;
    req_valid_v[1] = 2'b10;
    do_job(1, 2'b10, 8'h81, 8'h82, 8'h83, 8'h84, 16'd5, 5, 8'hA7, 8'hA7, 1'b0);

    // eoc on the very cycle the watchdog expires: eoc wins.
    req_valid_v[1] = 2'b01;
    do_job(1, 2'b01, 8'h77, 8'h78, 8'h79, 8'h7A, 16'd15, 15, 8'hC3, 8'hC3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
